bus_probe: RTL and testbench
============================

BUS_PROBE -- requirements
Module: bus_probe

Interface
REQ-001 SHALL have parameter DEBOUNCE_CYCLES, default 50000, meaning stable-input cycles (2..65535) required to accept a button level.
REQ-002 SHALL have port clk  input  1  sole clock; all state on rising edge.
REQ-003 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port addr  input  16  CPU address bus.
REQ-005 SHALL have port din  input  8  CPU read data.
REQ-006 SHALL have port dout  input  8  CPU write data.
REQ-007 SHALL have port rnw  input  1  1 = read cycle, 0 = write cycle.
REQ-008 SHALL have port bus_valid  input  1  one-cycle strobe marking a completed bus cycle.
REQ-009 SHALL have port btn_mode  input  1  raw, asynchronous mode button.
REQ-010 SHALL have port btn_hold  input  1  raw, asynchronous hold button.
REQ-011 SHALL have port match_addr  input  16  auto-hold address; ignored unless the macro in REQ-030 is defined.
REQ-012 SHALL have port data  output  16  value fed to the 4-digit seven-segment driver.
REQ-013 SHALL have port mode  output  2  current display mode.
REQ-014 SHALL have port held  output  1  1 = capture frozen.

Function
REQ-015 Each button SHALL pass a 2-flop synchronizer, then a debouncer; the accepted level changes only after the synchronized input differs from it for DEBOUNCE_CYCLES consecutive cycles; any bounce restarts the count.
REQ-016 A rising edge of an accepted level SHALL produce a single one-cycle press pulse.
REQ-017 Mode FSM states: CUR_ADDR(0) -> CUR_DATA(1) -> WR_ADDR(2) -> WR_DATA(3) -> CUR_ADDR; it SHALL advance one state per mode press, wrapping 3->0.
REQ-018 On bus_valid with held=0: cur_addr <= addr; cur_data <= {8'h00, rnw ? din : dout}.
REQ-019 On bus_valid with rnw=0 and held=0: wr_addr <= addr; wr_data <= {8'h00, dout}.
REQ-020 A hold press SHALL toggle held; while held=1, no capture register updates.
REQ-021 data SHALL be registered: the selected capture register per mode, visible 1 cycle after the capture or mode-change edge (2 cycles after bus_valid).
REQ-022 Mode changes while held SHALL remain effective, selecting among frozen registers.
REQ-023 Mode and hold presses in the same cycle SHALL both take effect.
REQ-024 bus_valid in the same cycle held goes 0->1 SHALL still capture; in the cycle held goes 1->0 it SHALL not capture.

Reset
REQ-025 Reset SHALL immediately force data=16'h0000, mode=0, held=0, all capture registers 0, synchronizers, counters and accepted levels 0.
REQ-026 A reset asserted mid-debounce SHALL discard the partial count; no press SHALL be generated on release for a button already held down until DEBOUNCE_CYCLES have elapsed after reset.
REQ-027 Reset release SHALL be sampled on clk only; no output changes in the first cycle after release other than by the function rules.

Configuration
REQ-028 The block SHALL compile with or without the macro BUS_PROBE_MATCH_EN.
REQ-029 With BUS_PROBE_MATCH_EN defined: bus_valid with addr==match_addr and held=0 SHALL capture that cycle (per REQ-018/019) and then set held=1; a hold press in the same cycle SHALL be overridden (held ends 1).
REQ-030 Without BUS_PROBE_MATCH_EN: match_addr SHALL be unused and no comparator SHALL be synthesized.

Structure
REQ-031 Mode encodings (CUR_ADDR, CUR_DATA, WR_ADDR, WR_DATA) and the 2-bit mode type SHALL live in shared package bus_probe_pkg.
REQ-032 Synchronizer, debouncer and edge detector SHALL be one sub-module, debounce, instantiated once per button.

Verification (DEBOUNCE_CYCLES=4)
REQ-033 Reset, then bus_valid with addr=16'hC012, rnw=1, din=8'h5A -> data=16'hC012 two cycles later; mode press -> data=16'h005A, mode=1.
REQ-034 Write cycle addr=16'h0400, dout=8'h41, followed by read addr=16'hF000 -> modes 2/3 show 16'h0400 and 16'h0041; mode 0 shows 16'hF000.
REQ-035 btn_mode toggled every 2 cycles for 20 cycles, then held high -> exactly one mode advance; four clean presses -> mode returns to 0.
REQ-036 Hold press, then bus_valid addr=16'h1234 -> held=1, data unchanged; second hold press, then bus_valid -> capture resumes.
REQ-037 With BUS_PROBE_MATCH_EN: match_addr=16'hFFFE, bus_valid addr=16'hFFFE -> held=1, data=16'hFFFE; later cycles are not captured; without the macro -> held stays 0.
REQ-038 Reset asserted mid-debounce with btn_hold high -> no press pulse; held stays 0 until 4 stable cycles after release.

Source files
------------

// File: rtl/bus_probe_pkg.sv
// Shared types for the bus probe: display-mode encoding and mode sequencing.
package bus_probe_pkg;

  typedef enum logic [1:0] {
    CUR_ADDR = 2'd0,
    CUR_DATA = 2'd1,
    WR_ADDR  = 2'd2,
    WR_DATA  = 2'd3
  } mode_t;

  localparam int unsigned CNT_W = 16;

  // Mode cycle order, wrapping from the last mode back to the first
  function automatic mode_t next_mode(input mode_t m);
    case (m)
      CUR_ADDR: next_mode = CUR_DATA;
      CUR_DATA: next_mode = WR_ADDR;
      WR_ADDR:  next_mode = WR_DATA;
      default:  next_mode = CUR_ADDR;
    endcase
  endfunction

endpackage

// File: rtl/bus_probe_debounce.sv
// Button conditioner: 2-flop synchronizer, debouncer and rising-edge detector.
// The accepted level flips after the synchronized input has differed from it
// for DEBOUNCE_CYCLES consecutive cycles; press_o pulses for one cycle on a
// 0->1 acceptance.
module debounce
  import bus_probe_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 50000
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_i,
  output logic press_o
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync1_q, sync2_q;
  logic             level_q, level_d;
  logic             press_q, press_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Synchronizer, counter, accepted level and press pulse registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      level_q <= 1'b0;
      press_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= btn_i;
      sync2_q <= sync1_q;
      level_q <= level_d;
      press_q <= press_d;
      cnt_q   <= cnt_d;
    end
  end

  // Count consecutive disagreeing cycles; any agreement restarts the count
  always_comb begin
    level_d = level_q;
    press_d = 1'b0;
    cnt_d   = '0;
    if (sync2_q != level_q) begin
      if (cnt_q == LAST) begin
        level_d = sync2_q;
        press_d = sync2_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  assign press_o = press_q;

endmodule

// File: rtl/bus_probe.sv
// Bus probe: captures CPU bus cycles and presents one capture register on a
// 16-bit display value selected by a button-driven mode FSM; a second button
// freezes capture. Optional macro BUS_PROBE_MATCH_EN adds auto-hold when a
// captured bus cycle hits match_addr.
module bus_probe
  import bus_probe_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 50000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] addr,
  input  logic [7:0]  din,
  input  logic [7:0]  dout,
  input  logic        rnw,
  input  logic        bus_valid,
  input  logic        btn_mode,
  input  logic        btn_hold,
  input  logic [15:0] match_addr,
  output logic [15:0] data,
  output logic [1:0]  mode,
  output logic        held
);

  logic        mode_press, hold_press;
  mode_t       mode_q, mode_d;
  logic        held_q, held_d;
  logic        cap;
  logic [15:0] cur_addr_q, cur_data_q, wr_addr_q, wr_data_q;
  logic [15:0] data_q, data_d;

  debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_mode (
    .clk    (clk),
    .rst    (reset),
    .btn_i  (btn_mode),
    .press_o(mode_press)
  );

  debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_hold (
    .clk    (clk),
    .rst    (reset),
    .btn_i  (btn_hold),
    .press_o(hold_press)
  );

  // Mode and hold state registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mode_q <= CUR_ADDR;
      held_q <= 1'b0;
    end else begin
      mode_q <= mode_d;
      held_q <= held_d;
    end
  end

  // Next mode/hold; capture uses the pre-update held so a hold taking effect
  // this cycle still captures and a release this cycle does not
  always_comb begin
    mode_d = mode_q;
    held_d = held_q;
    cap    = bus_valid && !held_q;
    if (mode_press) mode_d = next_mode(mode_q);
    if (hold_press) held_d = !held_q;
`ifdef BUS_PROBE_MATCH_EN
    if (cap && (addr == match_addr)) held_d = 1'b1;
`endif
  end

`ifndef BUS_PROBE_MATCH_EN
  logic unused_match;
  assign unused_match = ^match_addr;
`endif

  // Capture registers for the last bus cycle and the last write cycle
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cur_addr_q <= '0;
      cur_data_q <= '0;
      wr_addr_q  <= '0;
      wr_data_q  <= '0;
    end else if (cap) begin
      cur_addr_q <= addr;
      cur_data_q <= {8'h00, rnw ? din : dout};
      if (!rnw) begin
        wr_addr_q <= addr;
        wr_data_q <= {8'h00, dout};
      end
    end
  end

  // Select the capture register shown in the current mode
  always_comb begin
    data_d = cur_addr_q;
    case (mode_q)
      CUR_ADDR: data_d = cur_addr_q;
      CUR_DATA: data_d = cur_data_q;
      WR_ADDR:  data_d = wr_addr_q;
      WR_DATA:  data_d = wr_data_q;
      default:  data_d = cur_addr_q;
    endcase
  end

  // Registered display value
  always_ff @(posedge clk or posedge reset) begin
    if (reset) data_q <= '0;
    else       data_q <= data_d;
  end

  assign data = data_q;
  assign mode = mode_q;
  assign held = held_q;

endmodule

// File: tb/tb_bus_probe.sv
module tb_bus_probe;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] addr;
  logic [7:0]  din, dout;
  logic        rnw, bus_valid, btn_mode, btn_hold;
  logic [15:0] match_addr;
  logic [15:0] data;
  logic [1:0]  mode;
  logic        held;

  int n_cmp = 0;
  int n_err = 0;

  bus_probe #(.DEBOUNCE_CYCLES(4)) dut (
    .clk       (clk),
    .reset     (reset),
    .addr      (addr),
    .din       (din),
    .dout      (dout),
    .rnw       (rnw),
    .bus_valid (bus_valid),
    .btn_mode  (btn_mode),
    .btn_hold  (btn_hold),
    .match_addr(match_addr),
    .data      (data),
    .mode      (mode),
    .held      (held)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] a;
    logic        r;
    logic [7:0]  di;
    logic [7:0]  do_;
    logic [15:0] exp_addr;
    logic [15:0] exp_data;
  } vec_t;

  vec_t vecs[4];

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // One-cycle bus strobe; returns at the negedge right after the sampling edge
  task automatic bus(input logic [15:0] a, input logic r, input logic [7:0] di, input logic [7:0] d_o);
    @(negedge clk);
    addr = a; rnw = r; din = di; dout = d_o; bus_valid = 1'b1;
    @(negedge clk);
    bus_valid = 1'b0;
  endtask

  task automatic press_mode();
    @(negedge clk); btn_mode = 1'b1;
    repeat (10) @(negedge clk);
    btn_mode = 1'b0;
    repeat (10) @(negedge clk);
  endtask

  task automatic press_hold();
    @(negedge clk); btn_hold = 1'b1;
    repeat (10) @(negedge clk);
    btn_hold = 1'b0;
    repeat (10) @(negedge clk);
  endtask

  // Hold press with a bus write sampled on the exact edge where held toggles
  task automatic hold_press_with_write(input logic [15:0] a, input logic [7:0] d_o);
    @(negedge clk); btn_hold = 1'b1;
    repeat (6) @(negedge clk);
    addr = a; rnw = 1'b0; dout = d_o; bus_valid = 1'b1;
    @(negedge clk);
    bus_valid = 1'b0;
    @(negedge clk);
    btn_hold = 1'b0;
  endtask

  initial begin
    vecs[0] = '{16'hC012, 1'b1, 8'h5A, 8'h00, 16'hC012, 16'h005A};
    vecs[1] = '{16'h0400, 1'b0, 8'h33, 8'h41, 16'h0400, 16'h0041};
    vecs[2] = '{16'hF000, 1'b1, 8'hA5, 8'h77, 16'hF000, 16'h00A5};
    vecs[3] = '{16'h0001, 1'b0, 8'hFF, 8'h00, 16'h0001, 16'h0000};

    reset = 1'b1; addr = '0; din = '0; dout = '0; rnw = 1'b1; bus_valid = 1'b0;
    btn_mode = 1'b0; btn_hold = 1'b0; match_addr = 16'hFFFE;
    repeat (2) @(negedge clk);
    check("reset_data", data, 16'h0000);
    check("reset_mode", 16'(mode), 16'd0);
    check("reset_held", 16'(held), 16'd0);
    reset = 1'b0;

    // Basic capture latency and mode switch
    bus(16'hC012, 1'b1, 8'h5A, 8'h00);
    check("latency_early", data, 16'h0000);
    @(negedge clk);
    check("cap_addr", data, 16'hC012);
    press_mode();
    check("mode1", 16'(mode), 16'd1);
    check("mode1_data", data, 16'h005A);
    press_mode(); press_mode(); press_mode();
    check("mode_wrap", 16'(mode), 16'd0);

    // Table: mode 0 shows address, mode 1 shows data
    for (int unsigned i = 0; i < 4; i++) begin
      bus(vecs[i].a, vecs[i].r, vecs[i].di, vecs[i].do_);
      @(negedge clk);
      check($sformatf("tbl_addr%0d", i), data, vecs[i].exp_addr);
    end
    press_mode();
    for (int unsigned i = 0; i < 4; i++) begin
      bus(vecs[i].a, vecs[i].r, vecs[i].di, vecs[i].do_);
      @(negedge clk);
      check($sformatf("tbl_data%0d", i), data, vecs[i].exp_data);
    end

    // Write then read: write registers keep the write
    bus(16'h0400, 1'b0, 8'h00, 8'h41);
    bus(16'hF000, 1'b1, 8'h12, 8'h00);
    @(negedge clk);
    check("rd_data", data, 16'h0012);
    press_mode();
    check("wr_addr", data, 16'h0400);
    press_mode();
    check("wr_data", data, 16'h0041);
    press_mode();
    check("cur_addr", data, 16'hF000);

    // Bouncing button: no accept while bouncing, one advance once stable
    for (int i = 0; i < 10; i++) begin
      btn_mode = ~btn_mode;
      repeat (2) @(negedge clk);
    end
    repeat (4) @(negedge clk);
    check("bounce_none", 16'(mode), 16'd0);
    btn_mode = 1'b1;
    repeat (12) @(negedge clk);
    btn_mode = 1'b0;
    repeat (12) @(negedge clk);
    check("bounce_one", 16'(mode), 16'd1);
    check("bounce_data", data, 16'h0012);

    // Hold freezes capture; mode still changes among frozen registers
    press_hold();
    check("held_on", 16'(held), 16'd1);
    bus(16'h1234, 1'b1, 8'h99, 8'h00);
    @(negedge clk);
    check("held_frozen", data, 16'h0012);
    press_mode();
    check("held_mode2", data, 16'h0400);
    press_hold();
    check("held_off", 16'(held), 16'd0);
    bus(16'h1234, 1'b0, 8'h00, 8'h99);
    @(negedge clk);
    check("resume", data, 16'h1234);

    // Capture on the cycle hold engages; none on the cycle it releases
    hold_press_with_write(16'h2222, 8'h01);
    check("edge_hold_on", 16'(held), 16'd1);
    check("edge_cap", data, 16'h2222);
    repeat (10) @(negedge clk);
    hold_press_with_write(16'h3333, 8'h02);
    check("edge_hold_off", 16'(held), 16'd0);
    check("edge_nocap", data, 16'h2222);
    repeat (10) @(negedge clk);

    // Address match auto-hold
    bus(16'hFFFE, 1'b0, 8'h00, 8'h3C);
    @(negedge clk);
    check("match_cap", data, 16'hFFFE);
    bus(16'h5555, 1'b0, 8'h00, 8'h01);
    @(negedge clk);
`ifdef BUS_PROBE_MATCH_EN
    check("match_held", 16'(held), 16'd1);
    check("match_frozen", data, 16'hFFFE);
`else
    check("match_held", 16'(held), 16'd0);
    check("match_frozen", data, 16'h5555);
`endif

    // Reset mid-debounce with hold button down
    @(negedge clk); btn_hold = 1'b1;
    repeat (3) @(negedge clk);
    #2 reset = 1'b1;
    #1;
    check("async_data", data, 16'h0000);
    check("async_mode", 16'(mode), 16'd0);
    check("async_held", 16'(held), 16'd0);
    @(negedge clk); @(negedge clk);
    reset = 1'b0;
    repeat (6) @(negedge clk);
    check("rst_db_early", 16'(held), 16'd0);
    @(negedge clk);
    check("rst_db_press", 16'(held), 16'd1);
    btn_hold = 1'b0;
    repeat (10) @(negedge clk);
    check("rst_db_single", 16'(held), 16'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
